// File: rtl/sound_scheduler.sv
// sound_scheduler: arbitrates one-cycle sound-event requests, keeps the ones
// not yet served in a sticky pending register, and plays short fixed melodies
// into the tone generator. Note and gap durations are counted in slowClk ticks.
module sound_scheduler #(
    parameter int NOTE_TICKS = 2,   // slowClk ticks per melody note (1..15)
    parameter int GAP_TICKS  = 1    // silent slowClk ticks after a melody (0..15)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [1:0] gameState,
    input  logic       slowClk,
    output logic [3:0] tone,
    output logic       soundEnable,
    output logic       busy,
    output logic [1:0] activeEvent
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Terminal counts. When GAP_TICKS is 0 the GAP state is never entered,
    // so the wrapped value of GAP_LAST is never used.
    localparam logic [3:0] NOTE_LAST = 4'(NOTE_TICKS - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_TICKS - 1);

    state_t     state_q, state_d;
    logic [3:0] pending_q, pending_d;
    logic [3:0] tick_q, tick_d;
    logic [1:0] note_q, note_d;
    logic [1:0] active_q, active_d;
    logic [3:0] tone_q, tone_d;
    logic       en_q, en_d;

    logic [3:0] cand;
    logic [1:0] grant_idx;
    logic       preempt;
    logic       grant;

    // Melody ROM: note number idx of event ev.
    function automatic logic [3:0] melody_note(input logic [1:0] ev, input logic [1:0] idx);
        logic [3:0] n;
        case ({ev, idx})
            4'b00_00: n = 4'd11;
            4'b00_01: n = 4'd5;
            4'b01_00: n = 4'd0;
            4'b01_01: n = 4'd7;
            4'b10_00: n = 4'd4;
            4'b10_01: n = 4'd11;
            4'b10_10: n = 4'd7;
            4'b11_00: n = 4'd9;
            default:  n = 4'd0;
        endcase
        return n;
    endfunction

    // Index of the last note of each melody.
    function automatic logic [1:0] melody_last(input logic [1:0] ev);
        logic [1:0] l;
        case (ev)
            2'd0:    l = 2'd1;
            2'd1:    l = 2'd1;
            2'd2:    l = 2'd2;
            default: l = 2'd0;
        endcase
        return l;
    endfunction

    // Fixed priority, lowest index wins.
    function automatic logic [1:0] pick(input logic [3:0] c);
        logic [1:0] g;
        if (c[0])      g = 2'd0;
        else if (c[1]) g = 2'd1;
        else if (c[2]) g = 2'd2;
        else           g = 2'd3;
        return g;
    endfunction

    // Events that strictly outrank event a.
    function automatic logic [3:0] higher_mask(input logic [1:0] a);
        logic [3:0] m;
        case (a)
            2'd0:    m = 4'b0000;
            2'd1:    m = 4'b0001;
            2'd2:    m = 4'b0011;
            default: m = 4'b0111;
        endcase
        return m;
    endfunction

    // Next-state, pending bookkeeping and registered output values.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        tick_d    = tick_q;
        note_d    = note_q;
        active_d  = active_q;
        tone_d    = tone_q;
        en_d      = en_q;
        grant     = 1'b0;

        cand      = (gameState == 2'd1) ? (pending_q | req) : 4'b0000;
        grant_idx = pick(cand);
        preempt   = |(cand & higher_mask(active_q));

        if (gameState != 2'd1) begin
            // Outside active play everything is silenced and forgotten.
            state_d   = IDLE;
            pending_d = 4'b0000;
            tick_d    = 4'd0;
            note_d    = 2'd0;
            tone_d    = 4'd0;
            en_d      = 1'b0;
        end else begin
            pending_d = pending_q | req;
            case (state_q)
                IDLE: begin
                    en_d = 1'b0;
                    if (|cand) grant = 1'b1;
                end
                PLAY: begin
                    if (preempt) begin
                        grant = 1'b1;
                    end else if (slowClk) begin
                        if (tick_q == NOTE_LAST) begin
                            tick_d = 4'd0;
                            if (note_q == melody_last(active_q)) begin
                                en_d    = 1'b0;
                                state_d = (GAP_TICKS > 0) ? GAP : IDLE;
                            end else begin
                                note_d = note_q + 2'd1;
                                tone_d = melody_note(active_q, note_q + 2'd1);
                            end
                        end else begin
                            tick_d = tick_q + 4'd1;
                        end
                    end
                end
                GAP: begin
                    if (preempt) begin
                        grant = 1'b1;
                    end else if (slowClk) begin
                        if (tick_q == GAP_LAST) begin
                            tick_d  = 4'd0;
                            state_d = IDLE;
                        end else begin
                            tick_d = tick_q + 4'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            // A grant consumes both the pending bit and a same-cycle request.
            if (grant) begin
                pending_d[grant_idx] = 1'b0;
                active_d = grant_idx;
                note_d   = 2'd0;
                tick_d   = 4'd0;
                tone_d   = melody_note(grant_idx, 2'd0);
                en_d     = 1'b1;
                state_d  = PLAY;
            end
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 4'b0000;
            tick_q    <= 4'd0;
            note_q    <= 2'd0;
            active_q  <= 2'd0;
            tone_q    <= 4'd0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            note_q    <= note_d;
            active_q  <= active_d;
            tone_q    <= tone_d;
            en_q      <= en_d;
        end
    end

    assign tone        = tone_q;
    assign soundEnable = en_q;
    assign busy        = (state_q != IDLE);
    assign activeEvent = active_q;

endmodule

// File: doc/sound_scheduler.md
# sound_scheduler

Arbitrates one-cycle sound-event requests from the collision and rope logic, queues them, and sequences short multi-note melodies into the tone generator. It sits between the game-event sources and the tone/audio datapath, driving `tone` and `soundEnable`. Note durations are paced by the shared `slowClk` tick.

## Interface
- NOTE_TICKS, 2, slowClk ticks per melody note (legal 1..15)
- GAP_TICKS, 1, silent slowClk ticks after each melody (legal 0..15)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  4  one-cycle event pulses; [0] player-ball, [1] rope-ball, [2] present, [3] rope deploy
- gameState  in  2  game phase; events play only when ==1
- slowClk  in  1  one-cycle tick pulse, synchronous to clk
- tone  out  4  tone index to tone generator (registered)
- soundEnable  out  1  tone generator enable (registered)
- busy  out  1  high in PLAY or GAP
- activeEvent  out  2  index of event currently playing/gapping

## Operation
- Fixed melody ROM (note sequence, in order):
  - ev0: 11, 5
  - ev1: 0, 7
  - ev2: 4, 11, 7
  - ev3: 9
- `pending[3:0]` sticky register: bit i set on req[i]; cleared when event i is granted. A req[i] arriving in the same cycle that i is granted is consumed by that grant (no double play).
- Candidate set = pending | req. Priority is fixed, with the lowest index highest.
- States:
  - IDLE: soundEnable=0. If gameState==1 and candidate nonzero, grant the highest-priority index, load note 0 into tone, set soundEnable=1 and go to PLAY.
  - PLAY: soundEnable=1. Tick counter increments on each slowClk. When slowClk is high and counter==NOTE_TICKS-1, clear the counter and advance the note.
    - Non-last note: load the next note into tone.
    - Last note: go to GAP (GAP_TICKS>0, soundEnable=0) or to IDLE (GAP_TICKS=0).
  - GAP: soundEnable=0. Count GAP_TICKS slowClk pulses, then go to IDLE. tone holds its last value.
- Preemption: in PLAY or GAP, a candidate with strictly higher priority than activeEvent aborts the current event immediately.
  - The new event is granted, note 0 is loaded, the tick counter is cleared, and the state becomes PLAY.
  - The aborted event is discarded, not resumed.
- Equal- or lower-priority candidates stay pending until IDLE. A retrigger of the active event replays it after the current melody and gap finish.
- gameState != 1, from any state:
  - Next edge: IDLE, soundEnable=0, tone=0, pending cleared.
  - req is ignored while gameState != 1.
- Tick counter is 4 bits and never wraps, because it is cleared at NOTE_TICKS-1 or GAP_TICKS-1.

## Timing
- Reset (async, active-high): state=IDLE, tone=0, soundEnable=0, busy=0, activeEvent=0, pending=0, counters=0.
- Grant latency: req[i] high before edge k in IDLE gives tone/soundEnable valid after edge k (1 cycle).
- Preemption latency: 1 cycle from req to the new tone.
- Note duration: exactly NOTE_TICKS slowClk pulses, measured from entry to PLAY or from the previous note change.
- Total melody duration: notes × NOTE_TICKS slowClk pulses, plus GAP_TICKS.
- slowClk during the grant cycle is not counted.
- Simultaneous events in one cycle:
  - slowClk terminal count and higher-priority req: preemption wins.
  - Multiple req bits: the lowest index is granted and the rest stay pending.
- Reset mid-melody: outputs go to reset values asynchronously and all pending events are lost.

## Test plan
- Reset asserted mid-PLAY of ev2 → tone=0, soundEnable=0, busy=0 immediately; after release, no playback without a new req.
- gameState=1, NOTE_TICKS=2, GAP_TICKS=1, req[0] pulse → next cycle tone=11, en=1; after 2 slowClk tone=5; after 2 more en=0, GAP for 1 tick, then IDLE.
- req=4'b1010 in one cycle → ev1 plays (0,7); ev3 pending, plays tone=9 after ev1 melody plus gap.
- During ev2 note 2 (tone=11), req[0] → next cycle tone=11 (ev0 note 0), activeEvent=0, tick counter restarted; ev2 never resumes.
- During ev1 play, req[3] and req[1] → ev1 completes, then ev1 replays, then ev3 plays.
- gameState drops to 2 during PLAY with pending bits set → next cycle IDLE, tone=0, en=0, pending=0; req while gameState=2 produces no sound after returning to 1.
